// File: rtl/inv_subbyte_seq.sv
// Sequenced AES InvSubBytes: LANES shared inverse S-boxes walk the 16 state
// bytes in 16/LANES groups behind valid/ready handshakes on both sides.

module inv_sbox (
  input  logic [3:0] i_hi,
  input  logic [3:0] i_lo,
  output logic [7:0] o_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      p  = b[i] ? (p ^ aa) : p;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = x;
    for (int i = 0; i < 7; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) begin
      y[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8];
    end
    return y ^ 8'h05;
  endfunction

  logic [7:0] w_in;

  assign w_in   = {i_hi, i_lo};
  assign o_byte = gf_inv(inv_affine(w_in));

endmodule

module inv_subbyte_seq #(
  parameter int LANES = 1,
  parameter int CNT_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int GROUPS = 16 / LANES;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(GROUPS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_subbyte_seq: LANES must be 1, 2, 4, 8 or 16");
  end
  if ((GROUPS - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("inv_subbyte_seq: CNT_W too narrow for 16/LANES-1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [127:0]       r_cap;
  logic [127:0]       w_cap_nxt;
  logic [127:0]       r_out;
  logic [127:0]       w_out_nxt;
  logic [7:0]         w_lane_in  [LANES];
  logic [7:0]         w_lane_out [LANES];

  // Select the current group of captured bytes for the shared lanes.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      w_lane_in[j] = r_cap[8 * (int'(r_cnt) * LANES + j) +: 8];
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    inv_sbox u_sbox (
      .i_hi   (w_lane_in[j][7:4]),
      .i_lo   (w_lane_in[j][3:0]),
      .o_byte (w_lane_out[j])
    );
  end

  // Next-state, counter and datapath update.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cap_nxt   = r_cap;
    w_out_nxt   = r_out;
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            w_cap_nxt   = in_data;
            w_cnt_nxt   = '0;
            w_state_nxt = S_BUSY;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_BUSY: begin
          for (int j = 0; j < LANES; j++) begin
            w_out_nxt[8 * (int'(r_cnt) * LANES + j) +: 8] = w_lane_out[j];
          end
          if (r_cnt == LAST) begin
            w_state_nxt = S_DONE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cap   <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cap   <= w_cap_nxt;
      r_out   <= w_out_nxt;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_data  = r_out;

endmodule

// File: tb/tb_inv_subbyte_seq.sv
// Scoreboard bench for inv_subbyte_seq: three instances (LANES 1, 2, 4)
// driven one at a time; a negedge monitor checks every output handshake.

module tb_inv_subbyte_seq;

  typedef struct {
    int           id;
    logic [127:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush     [3];
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_data   [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_data  [3];
  logic         busy      [3];

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  inv_subbyte_seq #(.LANES(1), .CNT_W(4)) u_l1 (
    .clk(clk), .rst_n(rst_n), .flush(flush[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .in_data(in_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0]));

  inv_subbyte_seq #(.LANES(2), .CNT_W(4)) u_l2 (
    .clk(clk), .rst_n(rst_n), .flush(flush[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .in_data(in_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1]));

  inv_subbyte_seq #(.LANES(4), .CNT_W(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .flush(flush[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .in_data(in_data[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2]));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every completed output handshake must match the oldest expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (out_valid[k] === 1'b1 && out_ready[k] === 1'b1) begin
        if (q.size() == 0) begin
          chk($sformatf("unexpected_out_dut%0d", k), 128'd1, 128'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk($sformatf("out_id_dut%0d", k), 128'(k), 128'(e.id));
          chk($sformatf("out_data_dut%0d", k), out_data[k], e.data);
        end
      end
    end
  end

  // Accept one state on DUT k and measure edges from accept to out_valid.
  task automatic run(input int k, input logic [127:0] d, input logic [127:0] e,
                     input int n, input bit push);
    int cnt;
    cnt = 0;
    while (in_ready[k] !== 1'b1 && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    @(negedge clk);
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    if (push) q.push_back('{k, e});
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    chk($sformatf("busy_after_accept_dut%0d", k), 128'(busy[k]), 128'd1);
    cnt = 0;
    while (out_valid[k] !== 1'b1 && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk($sformatf("latency_dut%0d", k), 128'(cnt), 128'(n));
  endtask

  logic [7:0]   inv_row0 [16] = '{8'h52, 8'h09, 8'h6A, 8'hD5, 8'h30, 8'h36, 8'hA5, 8'h38,
                                  8'hBF, 8'h40, 8'hA3, 8'h9E, 8'h81, 8'hF3, 8'hD7, 8'hFB};
  logic [127:0] d_v;
  logic [127:0] e_v;
  bit           ok_v, ok_d, ok_r;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      flush[k] = 1'b0; in_valid[k] = 1'b0; in_data[k] = '0; out_ready[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_in_ready_dut%0d", k),  128'(in_ready[k]),  128'd1);
      chk($sformatf("rst_busy_dut%0d", k),      128'(busy[k]),      128'd0);
      chk($sformatf("rst_out_valid_dut%0d", k), 128'(out_valid[k]), 128'd0);
      chk($sformatf("rst_out_data_dut%0d", k),  out_data[k],        128'd0);
    end

    // LANES=1: all-zero state.
    run(0, 128'd0, {16{8'h52}}, 16, 1'b1);

    // LANES=4 vectors.
    run(2, {16{8'h63}}, 128'd0, 4, 1'b1);
    run(2, {16{8'hFF}}, {16{8'h7D}}, 4, 1'b1);
    for (int i = 0; i < 16; i++) begin
      d_v[8*i +: 8] = 8'(i);
      e_v[8*i +: 8] = inv_row0[i];
    end
    run(2, d_v, e_v, 4, 1'b1);

    // LANES=2 byte positions, held under back-pressure.
    d_v = {16{8'h63}};
    d_v[7:0] = 8'h00; d_v[15:8] = 8'h7C; d_v[23:16] = 8'h01;
    d_v[31:24] = 8'h02; d_v[39:32] = 8'h03;
    e_v = 128'd0;
    e_v[7:0] = 8'h52; e_v[15:8] = 8'h01; e_v[23:16] = 8'h09;
    e_v[31:24] = 8'h6A; e_v[39:32] = 8'hD5;
    out_ready[1] = 1'b0;
    run(1, d_v, e_v, 8, 1'b1);
    ok_v = 1'b1; ok_d = 1'b1; ok_r = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid[1] !== 1'b1) ok_v = 1'b0;
      if (out_data[1] !== e_v)   ok_d = 1'b0;
      if (in_ready[1] !== 1'b0)  ok_r = 1'b0;
    end
    chk("bp_out_valid_held", 128'(ok_v), 128'd1);
    chk("bp_out_data_stable", 128'(ok_d), 128'd1);
    chk("bp_in_ready_low", 128'(ok_r), 128'd1);
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 128'(in_ready[1]), 128'd1);
    chk("bp_release_out_valid", 128'(out_valid[1]), 128'd0);

    // flush together with in_valid while IDLE: not accepted.
    @(negedge clk);
    flush[0] = 1'b1; in_valid[0] = 1'b1; in_data[0] = {16{8'hAB}};
    @(posedge clk); #1;
    flush[0] = 1'b0; in_valid[0] = 1'b0;
    chk("flush_idle_busy", 128'(busy[0]), 128'd0);

    // flush mid-BUSY at cnt=7 on LANES=1.
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = {16{8'h11}};
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    flush[0] = 1'b1;
    @(posedge clk); #1;
    flush[0] = 1'b0;
    chk("flush_busy_in_ready", 128'(in_ready[0]), 128'd1);
    ok_v = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid[0] !== 1'b0) ok_v = 1'b0;
    end
    chk("flush_no_out_pulse", 128'(ok_v), 128'd1);
    run(0, {16{8'h63}}, 128'd0, 16, 1'b1);

    // Reset while DONE discards the result.
    out_ready[2] = 1'b0;
    run(2, {16{8'hFF}}, {16{8'h7D}}, 4, 1'b0);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("rst_done_out_valid", 128'(out_valid[2]), 128'd0);
    chk("rst_done_out_data", out_data[2], 128'd0);
    chk("rst_done_in_ready", 128'(in_ready[2]), 128'd1);
    out_ready[2] = 1'b1;

    // flush and reset together mid-BUSY: reset clears partial output.
    @(negedge clk);
    in_valid[2] = 1'b1; in_data[2] = {16{8'hFF}};
    @(posedge clk); #1;
    in_valid[2] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    flush[2] = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    flush[2] = 1'b0; rst_n = 1'b1;
    chk("rst_flush_out_data", out_data[2], 128'd0);
    chk("rst_flush_in_ready", 128'(in_ready[2]), 128'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 128'(q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
